// File: rtl/ws2812_pkg.sv
// Shared types and register map for the WS2812 frame scheduler.
package ws2812_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_NUM    = 2'd1;
  localparam logic [1:0] REG_PIXEL  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_OUT_EN = 2;
  localparam int CTRL_FLUSH  = 3;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_UNDER = 3;
  localparam int STAT_DONE  = 4;
  localparam int STAT_OVF   = 5;

  localparam int PIX_W = 24;

  typedef struct packed {
    logic        we;
    logic [1:0]  idx;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wb_req_t;

endpackage

// File: rtl/ws2812_pixel_fifo.sv
// First-word-fall-through pixel FIFO; rdata is the head entry whenever !empty.
module ws2812_pixel_fifo
  import ws2812_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [PIX_W-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [PIX_W-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ws2812_frame_scheduler.sv
// Wishbone-controlled WS2812 frame sequencer: pixel FIFO, bit serialiser and latch gap.
module ws2812_frame_scheduler
  import ws2812_pkg::*;
#(
  parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          T_BIT      = 50,
  parameter int          T0H        = 16,
  parameter int          T1H        = 32,
  parameter int          T_RESET    = 12000
) (
  input  logic        wb_clk_i,
  input  logic        rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        led_o,
  output logic        led_oeb_o,
  output logic        busy_o,
  output logic        irq_o
);

  localparam int BW = $clog2(T_BIT);
  localparam int GW = $clog2(T_RESET + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [BW-1:0] BIT_LAST = BW'(T_BIT - 1);
  localparam logic [BW-1:0] T0H_C    = BW'(T0H);
  localparam logic [BW-1:0] T1H_C    = BW'(T1H);
  localparam logic [GW-1:0] GAP_LAST = GW'(T_RESET - 1);

  // Wishbone decode
  wb_req_t req;
  logic    hit, acc, wr;
  logic    ctrl_wr, stat_wr, pix_wr, num_wr;
  logic    start, flush;

  assign req = '{we: wbs_we_i, idx: wbs_adr_i[3:2], dat: wbs_dat_i, sel: wbs_sel_i};
  assign hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]);
  // The ack register blocks back-to-back accesses, so each transfer acts once.
  assign acc = hit & ~wbs_ack_o;
  assign wr  = acc & req.we;

  assign ctrl_wr = wr & (req.idx == REG_CTRL) & req.sel[0];
  assign num_wr  = wr & (req.idx == REG_NUM) & req.sel[0] & ~busy_o;
  assign pix_wr  = wr & (req.idx == REG_PIXEL) & (req.sel[2:0] == 3'b111);
  assign stat_wr = wr & (req.idx == REG_STATUS);
  assign start   = ctrl_wr & req.dat[CTRL_START] & ~busy_o;
  assign flush   = ctrl_wr & req.dat[CTRL_FLUSH] & ~busy_o;

  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[1:0], wbs_sel_i[3], wbs_dat_i[31:24]};

  // Registers
  logic       irq_en, out_en;
  logic [7:0] num_leds;
  logic       underrun, done, ovf;

  // FIFO
  logic [PIX_W-1:0] fifo_rdata;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic [AW:0]      fifo_level;

  ws2812_pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (rst_n),
    .push  (pix_wr),
    .wdata (req.dat[PIX_W-1:0]),
    .pop   (fifo_pop),
    .flush (flush),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Frame FSM and serialiser datapath
  state_e           state, state_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic [4:0]       bit_idx, bit_idx_n;
  logic [7:0]       led_cnt, led_cnt_n;
  logic [GW-1:0]    gap_cnt, gap_cnt_n;
  logic [PIX_W-1:0] shreg, shreg_n;
  logic             led_n, done_set, und_set;

  assign busy_o = (state != ST_IDLE);

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    bit_idx_n = bit_idx;
    led_cnt_n = led_cnt;
    gap_cnt_n = gap_cnt;
    shreg_n   = shreg;
    fifo_pop  = 1'b0;
    led_n     = 1'b0;
    done_set  = 1'b0;
    und_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (num_leds == 8'd0) begin
            done_set = 1'b1;
          end else begin
            led_cnt_n = '0;
            state_n   = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shreg_n   = fifo_rdata;
          bit_idx_n = 5'd23;
          bit_cnt_n = '0;
          state_n   = ST_SEND;
        end else begin
          und_set   = 1'b1;
          gap_cnt_n = '0;
          state_n   = ST_LATCH;
        end
      end
      ST_SEND: begin
        led_n = (bit_cnt < (shreg[PIX_W-1] ? T1H_C : T0H_C));
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_n = '0;
          if (bit_idx != 5'd0) begin
            shreg_n   = {shreg[PIX_W-2:0], 1'b0};
            bit_idx_n = bit_idx - 5'd1;
          end else if (led_cnt == num_leds - 8'd1) begin
            gap_cnt_n = '0;
            state_n   = ST_LATCH;
          end else begin
            led_cnt_n = led_cnt + 8'd1;
            state_n   = ST_FETCH;
          end
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      ST_LATCH: begin
        if (gap_cnt == GAP_LAST) begin
          done_set = 1'b1;
          state_n  = ST_IDLE;
        end else begin
          gap_cnt_n = gap_cnt + 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // led_o is registered so the pad never sees comparator glitches.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      bit_idx <= '0;
      led_cnt <= '0;
      gap_cnt <= '0;
      shreg   <= '0;
      led_o   <= 1'b0;
    end else begin
      bit_cnt <= bit_cnt_n;
      bit_idx <= bit_idx_n;
      led_cnt <= led_cnt_n;
      gap_cnt <= gap_cnt_n;
      shreg   <= shreg_n;
      led_o   <= led_n;
    end
  end

  // Read mux
  logic [31:0] rd_data;

  always_comb begin
    rd_data = '0;
    case (req.idx)
      REG_CTRL: begin
        rd_data[CTRL_IRQ_EN] = irq_en;
        rd_data[CTRL_OUT_EN] = out_en;
      end
      REG_NUM:   rd_data[7:0] = num_leds;
      REG_PIXEL: rd_data[AW:0] = fifo_level;
      REG_STATUS: begin
        rd_data[STAT_BUSY]  = busy_o;
        rd_data[STAT_FULL]  = fifo_full;
        rd_data[STAT_EMPTY] = fifo_empty;
        rd_data[STAT_UNDER] = underrun;
        rd_data[STAT_DONE]  = done;
        rd_data[STAT_OVF]   = ovf;
      end
      default: rd_data = '0;
    endcase
  end

  // Sticky status: a same-cycle hardware set beats the W1C.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      irq_en    <= 1'b0;
      out_en    <= 1'b0;
      num_leds  <= '0;
      underrun  <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      irq_o     <= 1'b0;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= (acc && !req.we) ? rd_data : 32'h0;
      if (ctrl_wr) begin
        irq_en <= req.dat[CTRL_IRQ_EN];
        out_en <= req.dat[CTRL_OUT_EN];
      end
      if (num_wr) num_leds <= req.dat[7:0];
      underrun <= (underrun & ~(stat_wr & req.dat[STAT_UNDER])) | und_set;
      done     <= (done & ~(stat_wr & req.dat[STAT_DONE])) | done_set;
      ovf      <= (ovf & ~(stat_wr & req.dat[STAT_OVF])) | (pix_wr & fifo_full);
      irq_o    <= irq_en & (done | underrun);
    end
  end

  assign led_oeb_o = ~out_en;

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Scoreboard bench: expected pulse widths queued at START, checked as led_o pulses complete.
module tb_ws2812_frame_scheduler;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int T_BIT = 50, T0H = 16, T1H = 32, T_RESET = 12000, DEPTH = 8;

  logic        clk, rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_w, dat_r;
  logic        ack, led, oeb, busy, irq;

  ws2812_frame_scheduler dut (
    .wb_clk_i  (clk),
    .rst_n     (rst_n),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat_w),
    .wbs_dat_o (dat_r),
    .wbs_ack_o (ack),
    .led_o     (led),
    .led_oeb_o (oeb),
    .busy_o    (busy),
    .irq_o     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard and model state
  int          exp_q[$];
  logic [23:0] mdl_fifo[$];
  int          rise_total = 0, bit_in_frame = 0, hi_run = 0, since_rise = 0;
  int          busy_run = 0, busy_len = 0;
  logic        led_prev = 1'b0, busy_prev = 1'b0, frame_done = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hi_run = 0; since_rise = 0; bit_in_frame = 0; busy_run = 0;
      led_prev = 1'b0; busy_prev = 1'b0;
    end else begin
      if (led && !led_prev) begin
        rise_total++;
        if (bit_in_frame > 0)
          chk("bit_period", 32'(since_rise), (bit_in_frame % 24 == 0) ? 32'd51 : 32'd50);
        since_rise = 1;
      end else begin
        since_rise++;
      end
      if (led) hi_run++;
      if (!led && led_prev) begin
        if (exp_q.size() == 0) chk("unexpected_bit", 32'(hi_run), 32'd0);
        else chk("bit_width", 32'(hi_run), 32'(exp_q.pop_front()));
        hi_run = 0;
        bit_in_frame++;
      end
      if (busy) busy_run++;
      if (!busy && busy_prev) begin
        busy_len = busy_run;
        busy_run = 0;
        bit_in_frame = 0;
        frame_done = 1'b1;
      end
      led_prev  = led;
      busy_prev = busy;
    end
  end

  task automatic wb(input logic w, input logic [1:0] idx, input logic [31:0] d,
                    input logic [3:0] s, output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = BASE | {28'h0, idx, 2'b00}; dat_w = d;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack && lat < 10);
    if (!ack) chk("ack_timeout", 32'(ack), 32'd1);
    rd = dat_r;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] idx, input logic [31:0] d);
    logic [31:0] rd; int lat;
    wb(1'b1, idx, d, 4'hF, rd, lat);
  endtask

  task automatic rdr(input logic [1:0] idx, output logic [31:0] d);
    int lat;
    wb(1'b0, idx, 32'h0, 4'hF, d, lat);
  endtask

  task automatic push_px(input logic [23:0] px);
    wr(2'd2, {8'h0, px});
    if (mdl_fifo.size() < DEPTH) mdl_fifo.push_back(px);
  endtask

  // Programs NUM_LEDS, queues the expected pulses and writes CTRL; returns expected busy length.
  task automatic start_frame(input int num, input logic [31:0] ctrl, output int exp_busy);
    int n;
    logic [23:0] px;
    wr(2'd1, 32'(num));
    n = (num < mdl_fifo.size()) ? num : mdl_fifo.size();
    for (int i = 0; i < n; i++) begin
      px = mdl_fifo.pop_front();
      for (int b = 23; b >= 0; b--) exp_q.push_back(px[b] ? T1H : T0H);
    end
    exp_busy = (num == 0) ? 0 : n * (24 * T_BIT + 1) + ((n < num) ? 1 : 0) + T_RESET;
    frame_done = 1'b0;
    wr(2'd0, ctrl);
  endtask

  task automatic wait_frame(input string tag, input int exp_busy);
    for (int i = 0; i < 30000 && !frame_done; i++) @(posedge clk);
    chk({tag, "_done"}, 32'(frame_done), 32'd1);
    chk({tag, "_busy_len"}, 32'(busy_len), 32'(exp_busy));
    chk({tag, "_bits_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  logic [31:0] d;
  int          lat, eb, rises;

  initial begin
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; dat_w = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_oeb", 32'(oeb), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", dat_r, 32'd0);
    rst_n = 1'b1;

    // Reset status: empty only; ack one cycle after stb, single cycle
    wb(1'b0, 2'd3, 32'h0, 4'hF, d, lat);
    chk("ack_lat", 32'(lat), 32'd1);
    chk("stat_rst", d, 32'h4);
    @(posedge clk); #1;
    chk("ack_single", 32'(ack), 32'd0);

    // One pixel 0xAA0000
    push_px(24'hAA0000);
    start_frame(1, 32'h7, eb);
    chk("oeb_on", 32'(oeb), 32'd0);
    wait_frame("f1", eb);
    rdr(2'd3, d);
    chk("f1_stat", d, 32'h14);
    repeat (2) @(posedge clk); #1;
    chk("f1_irq", 32'(irq), 32'd1);
    wr(2'd3, 32'h10);
    repeat (2) @(posedge clk); #1;
    chk("f1_irq_clr", 32'(irq), 32'd0);

    // Underrun: 2 pixels for 3 LEDs
    push_px(24'($urandom));
    push_px(24'($urandom));
    start_frame(3, 32'h7, eb);
    wait_frame("f2", eb);
    rdr(2'd3, d);
    chk("f2_stat", d, 32'h1C);
    repeat (2) @(posedge clk); #1;
    chk("f2_irq", 32'(irq), 32'd1);
    wr(2'd3, 32'h18);
    repeat (2) @(posedge clk); #1;
    chk("f2_irq_clr", 32'(irq), 32'd0);

    // Overflow: ninth push dropped
    for (int i = 0; i < 9; i++) push_px(24'($urandom));
    rdr(2'd2, d);
    chk("ovf_level", d, 32'd8);
    rdr(2'd3, d);
    chk("ovf_stat", d, 32'h22);
    wr(2'd3, 32'h20);
    rdr(2'd3, d);
    chk("ovf_w1c", d, 32'h02);
    start_frame(8, 32'h7, eb);
    wait_frame("f3", eb);
    rdr(2'd3, d);
    chk("f3_stat", d, 32'h14);
    wr(2'd3, 32'h10);

    // Reset mid-frame during bit 10
    for (int i = 0; i < 4; i++) push_px(24'($urandom));
    start_frame(4, 32'h7, eb);
    for (int i = 0; i < 2000 && !(bit_in_frame == 10 && led); i++) begin
      @(posedge clk); #1;
    end
    chk("bit10_reached", 32'(bit_in_frame == 10 && led), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_led", 32'(led), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    mdl_fifo.delete();
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    rdr(2'd3, d);
    chk("mid_rst_stat", d, 32'h4);
    rdr(2'd2, d);
    chk("mid_rst_level", d, 32'd0);
    chk("mid_rst_oeb", 32'(oeb), 32'd1);

    // Frame after reset; START/FLUSH/NUM_LEDS while busy are ignored, streaming push kept
    push_px(24'h5A3CC3);
    start_frame(1, 32'h7, eb);
    wr(2'd1, 32'd5);
    wr(2'd0, 32'hF);
    push_px(24'h123456);
    wait_frame("f4", eb);
    rdr(2'd2, d);
    chk("f4_level", d, 32'd1);
    rdr(2'd1, d);
    chk("f4_num", d, 32'd1);
    wr(2'd0, 32'hE);
    mdl_fifo.delete();
    rdr(2'd2, d);
    chk("flush_level", d, 32'd0);
    wr(2'd3, 32'h10);

    // START with NUM_LEDS=0: DONE only, no line activity
    rises = rise_total;
    start_frame(0, 32'h7, eb);
    rdr(2'd3, d);
    chk("zero_stat", d, 32'h14);
    chk("zero_busy", 32'(busy), 32'd0);
    repeat (5) @(posedge clk); #1;
    chk("zero_rises", 32'(rise_total), 32'(rises));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
